// File: rtl/serial_rx_if.sv
// ---------------------------------------------------------------------------
// serial_rx_if
//   Bundles the receive-side serial line and the byte/status outputs of the
//   serial receiver.
//
//   Handshake: there is no back-pressure. rx_stb is a one-clock pulse; rx_dat
//   and rx_err are valid while rx_stb is high and are held stable until the
//   next rx_stb. The consumer must capture on rx_stb.
//
//   Signals:
//     rx_serial  raw async serial line, idle high (sender -> receiver)
//     rx_dat     last received byte
//     rx_stb     one-clock update strobe
//     rx_err     framing error of the last frame
//
//   Modports:
//     master  line driver / byte consumer (drives rx_serial)
//     slave   the receiver (drives rx_dat, rx_stb, rx_err)
// ---------------------------------------------------------------------------
interface serial_rx_if;
    logic       rx_serial;
    logic [7:0] rx_dat;
    logic       rx_stb;
    logic       rx_err;

    modport master (output rx_serial, input rx_dat, rx_stb, rx_err);
    modport slave  (input rx_serial, output rx_dat, rx_stb, rx_err);
endinterface

// File: rtl/serial_rx.sv
// ---------------------------------------------------------------------------
// serial_rx
//   Async serial receiver, 8N1, LSB first, bit period of sym_cnt system
//   clocks. The line is brought in through a 2-FF synchronizer and sampled
//   once per bit at mid-bit. A start bit that is high again at its mid-point
//   is rejected as a glitch; a low stop bit flags a framing error and the
//   receiver then waits in BRK until the line returns high.
//
//   Ports:
//     clk      system clock
//     rst      synchronous, active-high reset
//     rx       serial_rx_if.slave: rx_serial in; rx_dat, rx_stb, rx_err out
//     state_o  current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module serial_rx #(
    parameter int SCW     = 5,
    parameter int sym_cnt = 26
) (
    input  logic              clk,
    input  logic              rst,
    serial_rx_if.slave        rx,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam logic [SCW-1:0] RELOAD = SCW'(sym_cnt - 1);
    localparam logic [SCW-1:0] HALF   = SCW'((sym_cnt >> 1) - 1);

    state_t         state_q, state_d;
    logic           sync1_q, sync2_q;
    logic [SCW-1:0] cnt_q, cnt_d;
    logic [2:0]     bitn_q, bitn_d;
    logic [7:0]     sh_q, sh_d;
    logic [7:0]     dat_q, dat_d;
    logic           stb_q, stb_d;
    logic           err_q, err_d;

    logic rxs;
    logic tick;

    assign rxs  = sync2_q;
    assign tick = (cnt_q == '0);

    // Synchronizer resets to the idle level so a quiet line never looks like
    // a start edge coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx.rx_serial;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            sh_q    <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            sh_q    <= sh_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Free-running down-count that parks at zero; only the active states
        // reload it, so its value in IDLE/BRK does not matter.
        cnt_d   = tick ? cnt_q : cnt_q - 1'b1;
        bitn_d  = bitn_q;
        sh_d    = sh_q;
        dat_d   = dat_q;
        stb_d   = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    // Half a bit period lands the first sample mid start bit.
                    cnt_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    cnt_d = RELOAD;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        bitn_d  = 3'd0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d  = RELOAD;
                    sh_d   = {rxs, sh_q[7:1]};
                    bitn_d = bitn_q + 3'd1;
                    if (bitn_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = RELOAD;
                    dat_d = sh_q;
                    stb_d = 1'b1;
                    err_d = !rxs;
                    state_d = rxs ? IDLE : BRK;
                end
            end
            BRK: begin
                // A held-low line must go high before a new start is armed.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx.rx_dat = dat_q;
    assign rx.rx_stb = stb_q;
    assign rx.rx_err = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_serial_rx.sv
module tb_serial_rx;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_rx_if rx_a ();
  serial_rx_if rx_b ();
  logic [2:0] state_a;
  logic [2:0] state_b;

  serial_rx #(.SCW(5), .sym_cnt(26)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_a.slave),
    .state_o (state_a)
  );

  serial_rx #(.SCW(3), .sym_cnt(8)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_b.slave),
    .state_o (state_b)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];    // {err, dat} for the 26-clock receiver
  logic [8:0] exp_b_q[$];  // {err, dat} for the 8-clock receiver
  int n_cmp  = 0;
  int n_fail = 0;
  int stb_cnt_a = 0;
  int stb_cnt_b = 0;
  int push_a = 0;
  int push_b = 0;
  bit lat_arm = 1'b0;
  time t_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One 8N1 frame on line A; stop_hi=0 sends a low stop bit (framing error).
  task automatic send_a(input logic [7:0] b, input bit stop_hi);
    logic [9:0] fr;
    fr = {stop_hi, b, 1'b0};
    exp_q.push_back({~stop_hi, b});
    push_a++;
    for (int k = 0; k < 10; k++) begin
      rx_a.rx_serial = fr[k];
      if (k == 0 && lat_arm) t_start = $time;
      repeat (26) @(negedge clk);
    end
  endtask

  // One frame on line B with a bit time of pq/4 clocks (fractional rates
  // approximated by placing each edge at floor(k*pq/4)).
  task automatic send_b(input logic [7:0] b, input int pq);
    logic [9:0] fr;
    int prev;
    int nxt;
    fr = {1'b1, b, 1'b0};
    exp_b_q.push_back({1'b0, b});
    push_b++;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      nxt = ((k + 1) * pq) / 4;
      rx_b.rx_serial = fr[k];
      repeat (nxt - prev) @(negedge clk);
      prev = nxt;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for all expected frames to be consumed.
  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check(tag, exp_q.size() + exp_b_q.size(), 0);
  endtask

  // ---------------- monitors ----------------
  logic [7:0] prev_dat_a;
  logic       prev_err_a;
  logic       prev_rst;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && rx_a.rx_stb) begin
      stb_cnt_a++;
      if (exp_q.size() == 0) begin
        check("a_unexpected_stb", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("a_dat", rx_a.rx_dat, e[7:0]);
        check("a_err", rx_a.rx_err, e[8]);
      end
      if (lat_arm) begin
        check("a_latency_250", (($time - t_start) / 10 >= 249) && (($time - t_start) / 10 <= 251), 1);
        lat_arm = 1'b0;
      end
    end
    if (!rst && !prev_rst && !rx_a.rx_stb && ({rx_a.rx_err, rx_a.rx_dat} != {prev_err_a, prev_dat_a}))
      check("a_out_hold", {rx_a.rx_err, rx_a.rx_dat}, {prev_err_a, prev_dat_a});
    prev_dat_a = rx_a.rx_dat;
    prev_err_a = rx_a.rx_err;
    prev_rst   = rst;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && rx_b.rx_stb) begin
      stb_cnt_b++;
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_stb", 1, 0);
      end else begin
        e = exp_b_q.pop_front();
        check("b_dat", rx_b.rx_dat, e[7:0]);
        check("b_err", rx_b.rx_err, e[8]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] bytes_b [3];
    int rates [3];
    logic [7:0] f81;

    rx_a.rx_serial = 1'b1;
    rx_b.rx_serial = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_dat", rx_a.rx_dat, 8'h00);
    check("rst_stb", rx_a.rx_stb, 1'b0);
    check("rst_err", rx_a.rx_err, 1'b0);
    check("rst_state", state_a, 3'd0);
    idle(20);
    check("idle_state", state_a, 3'd0);

    // 1: clean 0x55 with latency measurement
    lat_arm = 1'b1;
    send_a(8'h55, 1'b1);
    drain("t1_drain");
    idle(30);

    // 2: back-to-back 0x00, 0xFF
    send_a(8'h00, 1'b1);
    send_a(8'hFF, 1'b1);
    drain("t2_drain");
    idle(30);

    // 3: short low glitch must not start a frame
    rx_a.rx_serial = 1'b0;
    idle(5);
    rx_a.rx_serial = 1'b1;
    idle(60);
    check("t3_glitch_state", state_a, 3'd0);
    send_a(8'hA3, 1'b1);
    drain("t3_drain");
    idle(30);

    // 4: framing error, line held low, then recovery
    send_a(8'h3C, 1'b0);
    idle(174);
    check("t4_err_sticky", rx_a.rx_err, 1'b1);
    check("t4_brk_state", state_a, 3'd4);
    rx_a.rx_serial = 1'b1;
    idle(40);
    send_a(8'h12, 1'b1);
    drain("t4_drain");
    idle(30);

    // 5: reset mid data bit 4 of 0x81; sender aborts too
    f81 = 8'h81;
    rx_a.rx_serial = 1'b0;
    idle(26);
    for (int k = 0; k < 4; k++) begin
      rx_a.rx_serial = f81[k];
      idle(26);
    end
    rx_a.rx_serial = f81[4];
    idle(13);
    check("t5_pre_rst_state", state_a, 3'd2);
    rst = 1'b1;
    rx_a.rx_serial = 1'b1;
    idle(1);
    check("t5_rst_dat", rx_a.rx_dat, 8'h00);
    check("t5_rst_state", state_a, 3'd0);
    rst = 1'b0;
    idle(300);
    check("t5_no_stb", stb_cnt_a, push_a);
    send_a(8'h81, 1'b1);
    drain("t5_drain");

    // 6: fast receiver, nominal and +/-0.25 clock bit times
    bytes_b[0] = 9'h001;
    bytes_b[1] = 9'h080;
    bytes_b[2] = 9'h0E7;
    rates[0] = 32;
    rates[1] = 33;
    rates[2] = 31;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        send_b(bytes_b[(i + r) % 3][7:0], rates[r]);
        idle($urandom_range(0, 6));
      end
    end
    drain("t6_drain");
    idle(20);

    // Final report
    check("a_strobe_count", stb_cnt_a, push_a);
    check("b_strobe_count", stb_cnt_b, push_b);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
